// File: rtl/logic_pod_pattern_gen_pkg.sv
// Shared types for the logic pod pattern generator: lane sample word, playback states,
// and a helper that broadcasts one level bit per lane across all samples of that lane.
package logic_pod_pattern_gen_pkg;

  localparam int unsigned LA_LANES           = 8;
  localparam int unsigned LA_SAMPLES_PER_CLK = 16;
  localparam int unsigned LA_WORD_BITS       = LA_LANES * LA_SAMPLES_PER_CLK;

  typedef struct packed {
    logic [LA_SAMPLES_PER_CLK-1:0] bits;
  } la_sample_t;

  typedef la_sample_t [LA_LANES-1:0] la_word_t;

  typedef enum logic [1:0] {
    PG_IDLE  = 2'd0,
    PG_RUN   = 2'd1,
    PG_DRAIN = 2'd2
  } pattern_state_t;

  function automatic la_word_t lane_fill(input logic [LA_LANES-1:0] level);
    la_word_t w;
    for (int unsigned i = 0; i < LA_LANES; i++) begin
      w[i].bits = {LA_SAMPLES_PER_CLK{level[i]}};
    end
    return w;
  endfunction

endpackage

// File: rtl/logic_pod_pattern_ram.sv
// Simple dual-port pattern store, read-first, with a two-register read path
// (array register then output register) so it maps onto block RAM.
module logic_pod_pattern_ram
  import logic_pod_pattern_gen_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  la_word_t             wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output la_word_t             rd_data
);

  la_word_t mem_q [DEPTH];
  la_word_t arr_q;
  la_word_t out_q;

  // Write and read share one process; non-blocking semantics give old data on collision.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      arr_q <= mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    out_q <= arr_q;
  end

  assign rd_data = out_q;

endmodule

// File: rtl/logic_pod_pattern_gen.sv
// Pattern playback engine: loops a stored 8-lane pattern through the read pipeline,
// applies per-lane polarity correction and drives the idle level when not playing.
module logic_pod_pattern_gen
  import logic_pod_pattern_gen_pkg::*;
#(
  parameter int unsigned          DEPTH       = 1024,
  parameter int unsigned          ADDR_BITS   = $clog2(DEPTH),
  parameter logic [LA_LANES-1:0]  LANE_INVERT = 8'h00
) (
  input  logic                 clk_312p5mhz,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  la_sample_t [LA_LANES-1:0] wr_data,
  input  logic                 start,
  input  logic                 stop,
  input  logic [ADDR_BITS-1:0] last_addr,
  input  logic [15:0]          loop_count,
  input  logic [LA_LANES-1:0]  idle_level,
  output logic                 busy,
  output logic                 done,
  output logic                 sample_valid,
  output la_sample_t [LA_LANES-1:0] samples
);

  pattern_state_t       state_q, state_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_BITS-1:0] last_addr_q, last_addr_d;
  logic [15:0]          pass_q, pass_d;
  logic                 v1_q, v1_d;
  logic                 v2_q, v2_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 sample_valid_q, sample_valid_d;
  la_word_t             samples_q, samples_d;
  logic                 rd_en_c;
  logic                 flush_c;
  la_word_t             rd_data;

  logic_pod_pattern_ram #(
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk     (clk_312p5mhz),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en_c),
    .rd_addr (rd_addr_q),
    .rd_data (rd_data)
  );

  // Next-state, read sequencing and output word selection.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    last_addr_d = last_addr_q;
    pass_d      = pass_q;
    rd_en_c     = 1'b0;
    done_d      = 1'b0;
    flush_c     = stop && (state_q != PG_IDLE);

    case (state_q)
      PG_IDLE: begin
        if (start && !stop) begin
          state_d     = PG_RUN;
          last_addr_d = last_addr;
          pass_d      = loop_count;
          rd_addr_d   = '0;
        end
      end
      PG_RUN: begin
        if (stop) begin
          state_d = PG_IDLE;
        end else begin
          rd_en_c = 1'b1;
          if (rd_addr_q == last_addr_q) begin
            rd_addr_d = '0;
            // pass_q == 0 means infinite looping: never count down
            if (pass_q == 16'd1) begin
              state_d = PG_DRAIN;
            end else if (pass_q != 16'd0) begin
              pass_d = 16'(pass_q - 16'd1);
            end
          end else begin
            rd_addr_d = ADDR_BITS'(rd_addr_q + ADDR_BITS'(1));
          end
        end
      end
      PG_DRAIN: begin
        if (stop) begin
          state_d = PG_IDLE;
        end else if (!v1_q && !v2_q) begin
          state_d = PG_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = PG_IDLE;
      end
    endcase

    v1_d           = rd_en_c;
    v2_d           = v1_q && !flush_c;
    sample_valid_d = v2_q && !flush_c;
    busy_d         = (state_d != PG_IDLE);

    if (sample_valid_d) begin
      samples_d = la_word_t'(rd_data ^ lane_fill(LANE_INVERT));
    end else begin
      samples_d = lane_fill(LA_LANES'(idle_level ^ LANE_INVERT));
    end
  end

  always_ff @(posedge clk_312p5mhz or posedge rst) begin
    if (rst) begin
      state_q        <= PG_IDLE;
      rd_addr_q      <= '0;
      last_addr_q    <= '0;
      pass_q         <= '0;
      v1_q           <= 1'b0;
      v2_q           <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      sample_valid_q <= 1'b0;
      samples_q      <= lane_fill(LANE_INVERT);
    end else begin
      state_q        <= state_d;
      rd_addr_q      <= rd_addr_d;
      last_addr_q    <= last_addr_d;
      pass_q         <= pass_d;
      v1_q           <= v1_d;
      v2_q           <= v2_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      sample_valid_q <= sample_valid_d;
      samples_q      <= samples_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_valid = sample_valid_q;
  assign samples      = samples_q;

endmodule

// File: doc/logic_pod_pattern_gen.md
Name: logic_pod_pattern_gen

Overview:
- Transmit-side counterpart of the logic pod capture datapath.
- Plays a stored 8-lane pattern at 16 samples per lane per clock (5 Gsps equivalent) in the 312.5 MHz domain.
- Output word format is identical to capture: la_sample_t[7:0], with bits[0] earliest in time.
- Output feeds a downstream 16:1 serializer stage, which is not part of this block. This block owns the pattern RAM, loop sequencing, idle level and polarity correction.

Parameters:
- DEPTH, 1024: pattern RAM depth in 128-bit words (power of 2).
- ADDR_BITS, $clog2(DEPTH): address width.
- LANE_INVERT, 8'h00: per-lane board polarity correction, XORed onto all 16 bits of that lane at the output register.

Ports:
- clk_312p5mhz  in  1  sole clock.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  pattern RAM write strobe.
- wr_addr  in  ADDR_BITS  write address.
- wr_data  in  la_sample_t[7:0]  write data (128 bits).
- start  in  1  begin playback (single-cycle pulse).
- stop  in  1  abort playback.
- last_addr  in  ADDR_BITS  inclusive final pattern address; sampled at start.
- loop_count  in  16  number of passes, 0 = infinite; sampled at start.
- idle_level  in  8  per-lane logical level driven while not playing.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse on natural completion.
- sample_valid  out  1  high while samples carries pattern data.
- samples  out  la_sample_t[7:0]  registered output word.

Behaviour:
- Reset values:
  - busy=0, done=0, sample_valid=0.
  - samples[i].bits = {16{LANE_INVERT[i]}}, i.e. logical 0 on every lane.
  - FSM=IDLE, all pipeline valids cleared. RAM contents are not reset.
- States:
  - IDLE: start && !stop -> RUN. Latch last_addr and loop_count; rd_addr=0.
  - RUN: one read per cycle, every cycle.
    - rd_addr==last_addr: wrap to 0 with no gap word.
    - At each wrap with finite loops: decrement the remaining-pass counter.
    - Final word of final pass issued -> DRAIN.
  - DRAIN: wait until the read pipeline is empty -> IDLE, pulse done.
- Latency:
  - RAM read is 2 cycles (array register plus output register), followed by the output register.
  - With start sampled at edge N, word 0 is visible after edge N+3, and consecutive words follow on consecutive edges.
  - done and the return to idle_level are visible on the same cycle, one edge after the last pattern word.
- Output mapping:
  - sample_valid=1: samples[i].bits = word[i].bits ^ {16{LANE_INVERT[i]}}.
  - Otherwise: samples[i].bits = {16{idle_level[i] ^ LANE_INVERT[i]}}.
- stop:
  - Sampled high at edge S in RUN or DRAIN: FSM -> IDLE and all pipeline valids flushed at S.
  - After edge S, samples=idle and sample_valid=0. done is not pulsed.
- Start edge cases:
  - start while busy: ignored.
  - start && stop in IDLE: stop wins, nothing happens.
- last_addr=0: a single word repeats every cycle.
- Writes are permitted in any state. The RAM is read-first: a same-cycle read of the written address returns old data.
- Mid-run rst: outputs take their reset values asynchronously. No done pulse; the next start after release behaves normally.
- Pass counter: 16-bit down-counter loaded from loop_count. Infinite mode (0) never decrements and never enters DRAIN unless stopped.

Decomposition:
- Shared package (alongside la_sample_t):
  - LA_LANES=8, LA_SAMPLES_PER_CLK=16.
  - Enum pattern_state_t {PG_IDLE, PG_RUN, PG_DRAIN}.
- One sub-module: logic_pod_pattern_ram.
  - Simple dual-port, DEPTH x 128, read-first.
  - 2-cycle registered read, BRAM-inferable.

Test Plan:
1. Load words k=addr in all lanes; last_addr=3, loop_count=2, idle_level=0, LANE_INVERT=0; start at edge 0 -> words 0,1,2,3,0,1,2,3 after edges 3..10 with sample_valid=1; after edge 11, done=1 for one cycle, busy=0, samples all zero.
2. last_addr=0, loop_count=0, word0=16'hA5A5 per lane; start at edge 0, stop before edge 20 -> 16'hA5A5 after edges 3..19; after edge 20 idle, sample_valid=0; done never asserts.
3. LANE_INVERT=8'h81, idle_level=8'h01, out of reset -> lane0=16'h0000, lane7=16'hFFFF, lanes1..6=16'h0000 during idle. Then play word 16'h00FF on all lanes -> lane0 and lane7 show 16'hFF00, others 16'h00FF.
4. rst pulsed mid-RUN (loop_count=0) -> immediately busy=0, sample_valid=0, samples=reset value, no done. A new start with loop_count=1 after release completes normally with done.
5. Infinite loop with last_addr=3; write addr 2 = 16'h1234 in the cycle addr 2 is read -> old data on that pass; 16'h1234 appears on the next pass.
6. start pulsed while busy, and start+stop together in IDLE -> both ignored: sequence and timing unchanged, FSM stays in IDLE respectively.
